cr16_alu: RTL and testbench

//  16-bit ALU of the CR16 datapath. Operands A and B are combined per a 4-bit opcode.

---
 rtl/cr16_alu.sv | 111 +++++++++++
 tb/tb_cr16_alu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cr16_alu.sv
// CR16 datapath ALU: combinational 16-bit result plus a registered 5-bit PSR flag set.
// O_STATUS bit order is {N, Z, F, L, C}.
module cr16_alu #(
    parameter int WIDTH = 16
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             I_ENABLE,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic [3:0]       I_OPCODE,
    output logic [WIDTH-1:0] O_C,
    output logic [4:0]       O_STATUS
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_ADDC  = 4'd2,
        OP_ADDCU = 4'd3,
        OP_SUB   = 4'd4,
        OP_MUL   = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_XOR   = 4'd8,
        OP_NOT   = 4'd9,
        OP_LSH   = 4'd10,
        OP_RSH   = 4'd11,
        OP_ALSH  = 4'd12,
        OP_ARSH  = 4'd13
    } opcode_t;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_sum_c;
    logic [MSB:0]   w_diff;
    logic [MSB:0]   w_res;
    logic           w_carry;
    logic           w_ovf;
    logic           w_neg;
    logic           w_zflag;
    logic           w_zero;
    logic [4:0]     r_status;

    always_comb begin
        w_sum   = {1'b0, I_A} + {1'b0, I_B};
        w_sum_c = w_sum + ONE;
        w_diff  = I_B - I_A;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_neg   = 1'b0;
        w_zflag = 1'b0;
        case (opcode_t'(I_OPCODE))
            OP_ADD: begin
                w_res   = w_sum[MSB:0];
                w_ovf   = (I_A[MSB] == I_B[MSB]) && (w_res[MSB] != I_A[MSB]);
                w_neg   = w_res[MSB];
                w_zflag = 1'b1;
            end
            OP_ADDU: begin
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_zflag = 1'b1;
            end
            OP_ADDC: begin
                w_res   = w_sum_c[MSB:0];
                w_ovf   = (I_A[MSB] == I_B[MSB]) && (w_res[MSB] != I_A[MSB]);
                w_neg   = w_res[MSB];
                w_zflag = 1'b1;
            end
            OP_ADDCU: begin
                w_res   = w_sum_c[MSB:0];
                w_carry = w_sum_c[WIDTH];
                w_zflag = 1'b1;
            end
            OP_SUB: begin
                // N is the true signed compare B < A, so it stays correct when F is set.
                w_res   = w_diff;
                w_ovf   = (I_A[MSB] != I_B[MSB]) && (w_res[MSB] != I_B[MSB]);
                w_neg   = $signed(I_B) < $signed(I_A);
                w_zflag = 1'b1;
            end
            // Low half of a product is identical for signed and unsigned operands.
            OP_MUL:           w_res = I_A * I_B;
            OP_AND:           w_res = I_A & I_B;
            OP_OR:            w_res = I_A | I_B;
            OP_XOR:           w_res = I_A ^ I_B;
            OP_NOT:           w_res = ~I_A;
            OP_LSH, OP_ALSH:  w_res = I_A << I_B;
            OP_RSH, OP_ARSH:  w_res = I_A >> I_B;
            default:          w_res = '0;
        endcase
        w_zero = w_zflag && (w_res == '0);
    end

    assign O_C = I_ENABLE ? w_res : '0;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_status <= '0;
        end else if (I_ENABLE) begin
            r_status <= {w_neg, w_zero, w_ovf, 1'b0, w_carry};
        end
    end

    assign O_STATUS = r_status;

endmodule

// File: tb/tb_cr16_alu.sv
// Self-checking bench for cr16_alu: directed spec vectors, reset/enable corner cases,
// then random operations compared against an integer-arithmetic reference model.
module tb_cr16_alu;

    logic        I_CLK = 1'b0;
    logic        I_NRESET;
    logic        I_ENABLE;
    logic [15:0] I_A;
    logic [15:0] I_B;
    logic [3:0]  I_OPCODE;
    logic [15:0] O_C;
    logic [4:0]  O_STATUS;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [4:0]  expStatus = 5'b0;
    logic [15:0] lastC;
    logic [4:0]  lastS;

    cr16_alu #(.WIDTH(16)) dut (
        .I_CLK    (I_CLK),
        .I_NRESET (I_NRESET),
        .I_ENABLE (I_ENABLE),
        .I_A      (I_A),
        .I_B      (I_B),
        .I_OPCODE (I_OPCODE),
        .O_C      (O_C),
        .O_STATUS (O_STATUS)
    );

    always #5 I_CLK = ~I_CLK;

    // Reference model: signed/unsigned results from plain integer arithmetic and range tests.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] c, output logic [4:0] st);
        int  sa, sb, ua, ub, r, sh;
        bit  carry, ovf, neg, zero;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        sh = int'(b);
        r = 0;
        carry = 0; ovf = 0; neg = 0; zero = 0;
        case (op)
            4'd0, 4'd2: begin
                r = sa + sb + ((op == 4'd2) ? 1 : 0);
                ovf = (r > 32767) || (r < -32768);
            end
            4'd1, 4'd3: begin
                r = ua + ub + ((op == 4'd3) ? 1 : 0);
                carry = (r > 65535);
            end
            4'd4: begin
                r = sb - sa;
                ovf = (r > 32767) || (r < -32768);
            end
            4'd5:  r = sa * sb;
            4'd6:  r = int'(a & b);
            4'd7:  r = int'(a | b);
            4'd8:  r = int'(a ^ b);
            4'd9:  r = 65535 - ua;
            4'd10, 4'd12: r = (sh >= 16) ? 0 : ua * (1 << sh);
            4'd11, 4'd13: r = (sh >= 16) ? 0 : ua / (1 << sh);
            default: r = 0;
        endcase
        c = r[15:0];
        if (op <= 4'd4) zero = (c == 16'h0000);
        if (op == 4'd0 || op == 4'd2) neg = c[15];
        if (op == 4'd4) neg = (sb < sa);
        st = {neg, zero, ovf, 1'b0, carry};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one op at the falling edge, checks O_C at once, then O_STATUS after the rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic en);
        logic [15:0] mc;
        logic [4:0]  ms;
        @(negedge I_CLK);
        I_OPCODE = op; I_A = a; I_B = b; I_ENABLE = en;
        model(op, a, b, mc, ms);
        #1;
        lastC = O_C;
        checkOutput($sformatf("C op=%0d a=%h b=%h en=%0b", op, a, b, en), O_C, en ? mc : 16'h0000);
        @(posedge I_CLK);
        #1;
        if (en) expStatus = ms;
        lastS = O_STATUS;
        checkOutput($sformatf("STATUS op=%0d a=%h b=%h en=%0b", op, a, b, en),
                    {11'b0, O_STATUS}, {11'b0, expStatus});
    endtask

    initial begin
        I_NRESET = 1'b0; I_ENABLE = 1'b0; I_A = '0; I_B = '0; I_OPCODE = '0;
        #2;
        checkOutput("reset status", {11'b0, O_STATUS}, 16'h0000);

        // Flags must not load while reset is held, even with a flag-producing op enabled.
        I_ENABLE = 1'b1; I_OPCODE = 4'd0; I_A = 16'h7C00; I_B = 16'h0400;
        @(posedge I_CLK); #1;
        checkOutput("status held in reset", {11'b0, O_STATUS}, 16'h0000);
        @(negedge I_CLK);
        I_NRESET = 1'b1;

        applyStimulus(4'd0, 16'h7C00, 16'h0400, 1'b1);
        checkOutput("spec ADD C", lastC, 16'h8000);
        checkOutput("spec ADD status", {11'b0, lastS}, 16'h0014);
        applyStimulus(4'd1, 16'hFC00, 16'h0400, 1'b1);
        checkOutput("spec ADDU C", lastC, 16'h0000);
        checkOutput("spec ADDU status", {11'b0, lastS}, 16'h0009);
        applyStimulus(4'd3, 16'hFC00, 16'h0000, 1'b1);
        checkOutput("spec ADDCU C", lastC, 16'hFC01);
        checkOutput("spec ADDCU status", {11'b0, lastS}, 16'h0000);
        applyStimulus(4'd2, 16'h8000, 16'h8000, 1'b1);
        checkOutput("spec ADDC C", lastC, 16'h0001);
        checkOutput("spec ADDC status", {11'b0, lastS}, 16'h0004);
        applyStimulus(4'd4, 16'h0400, 16'h8000, 1'b1);
        checkOutput("spec SUB C", lastC, 16'h7C00);
        checkOutput("spec SUB status", {11'b0, lastS}, 16'h0014);
        applyStimulus(4'd4, 16'h1234, 16'h1234, 1'b1);
        checkOutput("spec SUB eq C", lastC, 16'h0000);
        checkOutput("spec SUB eq status", {11'b0, lastS}, 16'h0008);
        applyStimulus(4'd5, 16'hFC00, 16'h0400, 1'b1);
        checkOutput("spec MUL C", lastC, 16'h0000);
        applyStimulus(4'd9, 16'h0400, 16'hFFFF, 1'b1);
        checkOutput("spec NOT C", lastC, 16'hFBFF);
        applyStimulus(4'd10, 16'h0401, 16'h0003, 1'b1);
        checkOutput("spec LSH C", lastC, 16'h2008);
        applyStimulus(4'd13, 16'h8000, 16'h0001, 1'b1);
        checkOutput("spec ARSH C", lastC, 16'h4000);
        for (int op = 10; op <= 13; op++) begin
            applyStimulus(4'(op), 16'hFFFF, 16'h8000, 1'b1);
            checkOutput($sformatf("spec shift op=%0d B=8000", op), lastC, 16'h0000);
        end
        applyStimulus(4'd11, 16'hFFFF, 16'hFC00, 1'b1);
        applyStimulus(4'd12, 16'h0001, 16'h000F, 1'b1);
        applyStimulus(4'd14, 16'h1234, 16'h5678, 1'b1);
        applyStimulus(4'd15, 16'hFFFF, 16'hFFFF, 1'b1);

        // Enable low: result forced to zero and flags held from the prior enabled op.
        applyStimulus(4'd4, 16'h0400, 16'h8000, 1'b1);
        applyStimulus(4'd1, 16'hFC00, 16'h0400, 1'b0);
        checkOutput("enable low status held", {11'b0, lastS}, 16'h0014);

        // Mid-cycle reset: status must clear without waiting for a clock edge.
        @(negedge I_CLK); #2;
        I_NRESET = 1'b0;
        #1;
        checkOutput("async reset clears status", {11'b0, O_STATUS}, 16'h0000);
        expStatus = 5'b0;
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        applyStimulus(4'd1, 16'hFC00, 16'h0400, 1'b1);
        checkOutput("first edge after reset", {11'b0, lastS}, 16'h0009);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            if (op >= 4'd10 && op <= 4'd13 && $urandom_range(0, 3) != 0) b = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) b = a;
            applyStimulus(op, a, b, ($urandom_range(0, 7) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
